// File: rtl/npc_seq_unit_if.sv
// Fetch/redirect bus of the next-PC sequencer. master is the sequencer side,
// slave is the fetch/execute side driving redirects and fetch_ready.
interface npc_seq_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            fetch_ready_i;
    logic            stall_i;
    logic            redir_valid_i;
    logic [1:0]      redir_sel_i;
    logic            cond_taken_i;
    logic [XLEN-1:0] redir_pc_i;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] trap_vec_i;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic            misalign_o;
    logic [XLEN-1:0] misalign_addr_o;
    logic            redir_taken_o;

    modport master (
        input  fetch_ready_i, stall_i, redir_valid_i, redir_sel_i, cond_taken_i,
        input  redir_pc_i, imm_i, rs1_i, trap_vec_i,
        output pc_o, pc_valid_o, misalign_o, misalign_addr_o, redir_taken_o
    );

    modport slave (
        output fetch_ready_i, stall_i, redir_valid_i, redir_sel_i, cond_taken_i,
        output redir_pc_i, imm_i, rs1_i, trap_vec_i,
        input  pc_o, pc_valid_o, misalign_o, misalign_addr_o, redir_taken_o
    );
endinterface

// File: rtl/npc_seq_unit.sv
// Sequential next-PC generator: owns the PC, hands fetch addresses out over
// valid/ready, applies execute redirects and parks in FAULT on misaligned targets.
module npc_seq_unit #(
    parameter int unsigned XLEN       = 32,
    parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
    parameter int unsigned ALIGN_MASK = 3,
    parameter int unsigned STEP       = 4
) (
    input logic           clk,
    input logic           rst_n,
    npc_seq_unit_if.master bus
);
    localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_VEC);
    localparam logic [XLEN-1:0] AMASK  = XLEN'(ALIGN_MASK);
    localparam logic [XLEN-1:0] STEP_X = XLEN'(STEP);

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;
    typedef enum logic [1:0] {SEL_BR = 2'b00, SEL_JAL = 2'b01, SEL_JALR = 2'b10, SEL_TRAP = 2'b11} sel_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n, maddr, maddr_n, target;
    logic            pc_valid, pc_valid_n, mis, mis_n, taken, taken_n;
    logic            eff_redir, bad_align, is_trap;

    always_comb begin
        target = bus.redir_pc_i + bus.imm_i;
        case (sel_t'(bus.redir_sel_i))
            SEL_JALR: target = (bus.rs1_i + bus.imm_i) & ~XLEN'(1);
            SEL_TRAP: target = bus.trap_vec_i;
            default:  target = bus.redir_pc_i + bus.imm_i;
        endcase
    end

    // A not-taken branch is not a redirect at all.
    assign is_trap   = bus.redir_sel_i == SEL_TRAP;
    assign eff_redir = bus.redir_valid_i & ((bus.redir_sel_i != SEL_BR) | bus.cond_taken_i);
    assign bad_align = !is_trap && ((target & AMASK) != '0);

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        pc_valid_n = pc_valid;
        mis_n      = mis;
        maddr_n    = maddr;
        taken_n    = 1'b0;
        case (state)
            BOOT: begin
                state_n    = RUN;
                pc_valid_n = 1'b1;
            end
            RUN: begin
                if (eff_redir) begin
                    if (bad_align) begin
                        state_n    = FAULT;
                        pc_valid_n = 1'b0;
                        mis_n      = 1'b1;
                        maddr_n    = target;
                    end else begin
                        pc_n    = target;
                        taken_n = 1'b1;
                    end
                end else if (!bus.stall_i && pc_valid && bus.fetch_ready_i) begin
                    pc_n = pc + STEP_X;
                end
            end
            FAULT: begin
                if (bus.redir_valid_i && is_trap) begin
                    state_n    = RUN;
                    pc_n       = bus.trap_vec_i;
                    pc_valid_n = 1'b1;
                    mis_n      = 1'b0;
                    taken_n    = 1'b1;
                end
            end
            default: begin
                state_n    = BOOT;
                pc_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RST_PC;
            pc_valid <= 1'b0;
            mis      <= 1'b0;
            maddr    <= '0;
            taken    <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            pc_valid <= pc_valid_n;
            mis      <= mis_n;
            maddr    <= maddr_n;
            taken    <= taken_n;
        end
    end

    assign bus.pc_o            = pc;
    assign bus.pc_valid_o      = pc_valid;
    assign bus.misalign_o      = mis;
    assign bus.misalign_addr_o = maddr;
    assign bus.redir_taken_o   = taken;
endmodule
